seg_adder: RTL and testbench



---
 rtl/seg_adder.sv | 104 ++++++++++
 tb/tb_seg_adder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seg_adder.sv
// Multi-cycle segmented adder/subtractor: adds one CHUNK_W-bit slice per cycle,
// LSB first, with the inter-slice carry held in a register.
package calculator_pkg;
    localparam int unsigned DATA_W = 32;
endpackage

module seg_adder #(
    parameter int unsigned DATA_W  = calculator_pkg::DATA_W,
    parameter int unsigned CHUNK_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              sub_i,
    input  logic              carry_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] sum_o,
    output logic              carry_o,
    output logic              overflow_o
);

    localparam int unsigned NUM_CHUNKS = DATA_W / CHUNK_W;
    localparam int unsigned CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    if ((DATA_W % CHUNK_W) != 0) begin : g_bad_chunk
        $error("seg_adder: CHUNK_W must divide DATA_W exactly");
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                               state;
    logic [NUM_CHUNKS-1:0][CHUNK_W-1:0]   a_q;
    logic [NUM_CHUNKS-1:0][CHUNK_W-1:0]   b_q;
    logic [NUM_CHUNKS-1:0][CHUNK_W-1:0]   sum_q;
    logic                                 carry_q;
    logic                                 carry_out_q;
    logic                                 overflow_q;
    logic [CNT_W-1:0]                     cnt;

    logic [CHUNK_W-1:0] slice_a;
    logic [CHUNK_W-1:0] slice_b;
    logic [CHUNK_W:0]   chunk_sum;
    logic               msb_cin;

    // Current slice addition; carry into the slice MSB recovered from the sum bit.
    always_comb begin
        slice_a   = a_q[cnt];
        slice_b   = b_q[cnt];
        chunk_sum = {1'b0, slice_a} + {1'b0, slice_b} + (CHUNK_W+1)'(carry_q);
        msb_cin   = chunk_sum[CHUNK_W-1] ^ slice_a[CHUNK_W-1] ^ slice_b[CHUNK_W-1];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        a_q     <= a_i;
                        b_q     <= sub_i ? ~b_i : b_i;
                        carry_q <= sub_i | carry_i;
                        cnt     <= '0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    sum_q[cnt] <= chunk_sum[CHUNK_W-1:0];
                    carry_q    <= chunk_sum[CHUNK_W];
                    cnt        <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(NUM_CHUNKS - 1)) begin
                        carry_out_q <= chunk_sum[CHUNK_W];
                        overflow_q  <= msb_cin ^ chunk_sum[CHUNK_W];
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready_o    = (state == IDLE);
    assign valid_o    = (state == DONE);
    assign sum_o      = sum_q;
    assign carry_o    = carry_out_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_seg_adder.sv
// Bench for seg_adder: three configurations (32/8, 32/32, 16/4) checked against
// an arithmetic reference model, with backpressure and mid-operation reset.
module tb_seg_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a, b;
    logic        sub, cin;
    logic [2:0]  vin, rin, vout, rout, cout_w, ovf_w;
    logic [31:0] sum_w [3];
    logic [15:0] sum16;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seg_adder #(.DATA_W(32), .CHUNK_W(8)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(vin[0]), .ready_o(rout[0]),
        .a_i(a), .b_i(b), .sub_i(sub), .carry_i(cin),
        .valid_o(vout[0]), .ready_i(rin[0]), .sum_o(sum_w[0]),
        .carry_o(cout_w[0]), .overflow_o(ovf_w[0]));

    seg_adder #(.DATA_W(32), .CHUNK_W(32)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(vin[1]), .ready_o(rout[1]),
        .a_i(a), .b_i(b), .sub_i(sub), .carry_i(cin),
        .valid_o(vout[1]), .ready_i(rin[1]), .sum_o(sum_w[1]),
        .carry_o(cout_w[1]), .overflow_o(ovf_w[1]));

    seg_adder #(.DATA_W(16), .CHUNK_W(4)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(vin[2]), .ready_o(rout[2]),
        .a_i(a[15:0]), .b_i(b[15:0]), .sub_i(sub), .carry_i(cin),
        .valid_o(vout[2]), .ready_i(rin[2]), .sum_o(sum16),
        .carry_o(cout_w[2]), .overflow_o(ovf_w[2]));

    assign sum_w[2] = {16'h0, sum16};

    function automatic int width_of(input int idx);
        return (idx == 2) ? 16 : 32;
    endfunction

    function automatic int chunks_of(input int idx);
        return (idx == 1) ? 1 : 4;
    endfunction

    // Reference: plain integer arithmetic on W-bit operands.
    task automatic model(input int w, input logic [31:0] av, input logic [31:0] bv,
                         input logic s, input logic c,
                         output logic [31:0] es, output logic ec, output logic eo);
        longint unsigned mask, aa, bb, full;
        logic sa, sb, ss;
        mask = (64'd1 << w) - 64'd1;
        aa   = {32'h0, av} & mask;
        bb   = (s ? ~{32'h0, bv} : {32'h0, bv}) & mask;
        full = aa + bb + (s ? 64'd1 : {63'h0, c});
        es   = 32'(full & mask);
        ec   = full[w];
        sa   = aa[w-1];
        sb   = bb[w-1];
        ss   = full[w-1];
        eo   = (sa == sb) && (ss != sa);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and check latency and result; leaves the DUT in DONE.
    task automatic run_op(input int idx, input logic [31:0] av, input logic [31:0] bv,
                          input logic s, input logic c,
                          input logic [31:0] es, input logic ec, input logic eo);
        int n;
        @(negedge clk);
        a = av; b = bv; sub = s; cin = c;
        vin[idx] = 1'b1;
        rin[idx] = 1'b0;
        chk("ready_idle", 32'(rout[idx]), 32'd1);
        @(posedge clk);
        #1 vin[idx] = 1'b0;
        n = 0;
        while (vout[idx] !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        chk("latency", 32'(n), 32'(chunks_of(idx)));
        chk("sum", sum_w[idx], es);
        chk("carry", 32'(cout_w[idx]), 32'(ec));
        chk("overflow", 32'(ovf_w[idx]), 32'(eo));
    endtask

    task automatic drain(input int idx);
        @(negedge clk);
        rin[idx] = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_done", 32'(rout[idx]), 32'd1);
        chk("valid_after_done", 32'(vout[idx]), 32'd0);
        rin[idx] = 1'b0;
    endtask

    task automatic run_model(input int idx, input logic [31:0] av, input logic [31:0] bv,
                             input logic s, input logic c);
        logic [31:0] es;
        logic ec, eo;
        model(width_of(idx), av, bv, s, c, es, ec, eo);
        run_op(idx, av, bv, s, c, es, ec, eo);
        drain(idx);
    endtask

    logic [31:0] bp_sum;

    initial begin
        rst_n = 1'b0;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        vin = '0; rin = '0;
        #12;
        for (int i = 0; i < 3; i++) begin
            chk("rst_ready", 32'(rout[i]), 32'd1);
            chk("rst_valid", 32'(vout[i]), 32'd0);
            chk("rst_sum", sum_w[i], 32'd0);
            chk("rst_carry", 32'(cout_w[i]), 32'd0);
            chk("rst_ovf", 32'(ovf_w[i]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors for both 32-bit configurations.
        for (int i = 0; i < 2; i++) begin
            run_op(i, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0); drain(i);
            run_op(i, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1); drain(i);
            run_op(i, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0); drain(i);
            run_op(i, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0); drain(i);
            run_op(i, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0); drain(i);
            run_op(i, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1); drain(i);
            run_op(i, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0); drain(i);
            run_op(i, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1); drain(i);
        end

        // Directed vectors for the 16-bit configuration.
        run_op(2, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1); drain(2);
        run_op(2, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0); drain(2);
        run_op(2, 32'h0FFF, 32'h0000, 1'b0, 1'b1, 32'h1000, 1'b0, 1'b0); drain(2);
        run_op(2, 32'h0005, 32'h0007, 1'b1, 1'b1, 32'hFFFE, 1'b0, 1'b0); drain(2);
        run_op(2, 32'h8000, 32'h0001, 1'b1, 1'b0, 32'h7FFF, 1'b1, 1'b1); drain(2);

        // Random operations on every configuration.
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 30; k++) begin
                run_model(i, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        // Backpressure: result held for 10 cycles while new operands are offered.
        run_op(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
        bp_sum = 32'h2345_6789;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
            vin[0] = 1'b1;
            @(posedge clk);
            #1;
            chk("bp_sum", sum_w[0], bp_sum);
            chk("bp_valid", 32'(vout[0]), 32'd1);
            chk("bp_ready", 32'(rout[0]), 32'd0);
        end
        vin[0] = 1'b0;
        drain(0);
        run_model(0, 32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 1'b0);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        a = 32'h1111_1111; b = 32'h2222_2222; sub = 1'b0; cin = 1'b0;
        vin[0] = 1'b1;
        @(posedge clk);
        #1 vin[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(vout[0]), 32'd0);
        chk("arst_ready", 32'(rout[0]), 32'd1);
        chk("arst_sum", sum_w[0], 32'd0);
        chk("arst_carry", 32'(cout_w[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0);
        drain(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
